// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the host-side UART load/compute/unload link.
package uart_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_INS,
    SEND_DATA,
    RECV_RES,
    DONE
  } link_state_t;

  typedef enum logic [2:0] {
    FETCH,
    LATCH,
    PULSE,
    WAIT_LO,
    WAIT_HI
  } tx_sub_t;

  // Number of UART bytes needed to carry one word of the given width.
  function automatic int unsigned bytes_per_word(input int unsigned width,
                                                 input int unsigned uart_width);
    return (width + uart_width - 1) / uart_width;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Splits one loaded word into UART bytes, LSB first, with the tx_ready handshake.
// Sits in FETCH until load; the word is captured one cycle later (LATCH), which
// lines up with a synchronous read port addressed in the load cycle.
module word_byte_serializer
  import uart_link_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 60,
  parameter int unsigned UART_WIDTH = 8,
  localparam int unsigned NUM_BYTES = bytes_per_word(WORD_WIDTH, UART_WIDTH),
  localparam int unsigned CNT_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [CNT_WIDTH-1:0]  last_byte,
  input  logic                  tx_ready,
  output logic                  txByteStart,
  output logic [UART_WIDTH-1:0] byteForTx,
  output logic                  word_sent
);

  localparam int unsigned SHIFT_WIDTH = NUM_BYTES * UART_WIDTH;

  tx_sub_t                sub;
  logic [SHIFT_WIDTH-1:0] shift;
  logic [CNT_WIDTH-1:0]   byte_idx;
  logic [CNT_WIDTH-1:0]   last_idx;

  // Per-word byte sequencing: latch, then pulse / wait low / wait high per byte.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      sub         <= FETCH;
      shift       <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      txByteStart <= 1'b0;
      byteForTx   <= '0;
      word_sent   <= 1'b0;
    end else begin
      txByteStart <= 1'b0;
      word_sent   <= 1'b0;
      case (sub)
        FETCH: begin
          if (load) begin
            last_idx <= last_byte;
            sub      <= LATCH;
          end
        end
        LATCH: begin
          shift    <= SHIFT_WIDTH'(word);
          byte_idx <= '0;
          sub      <= PULSE;
        end
        PULSE: begin
          if (tx_ready) begin
            txByteStart <= 1'b1;
            byteForTx   <= shift[UART_WIDTH-1:0];
            sub         <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_ready) sub <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_ready) begin
            shift <= shift >> UART_WIDTH;
            if (byte_idx == last_idx) begin
              word_sent <= 1'b1;
              sub       <= FETCH;
            end else begin
              byte_idx <= byte_idx + CNT_WIDTH'(1);
              sub      <= PULSE;
            end
          end
        end
        default: sub <= FETCH;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_link.sv
// Host end of the UART link: streams the instruction image and data image out,
// then collects the result words sent back and writes them to the result RAM.
module uart_host_link
  import uart_link_pkg::*;
#(
  parameter int unsigned INS_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH      = 60,
  parameter int unsigned INS_ADDR_WIDTH  = 8,
  parameter int unsigned DATA_ADDR_WIDTH = 12,
  parameter int unsigned UART_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic [DATA_ADDR_WIDTH-1:0] data_last_addr,
  input  logic [DATA_ADDR_WIDTH-1:0] res_start_addr,
  input  logic [DATA_ADDR_WIDTH-1:0] res_end_addr,
  output logic [INS_ADDR_WIDTH-1:0]  ins_rd_addr,
  input  logic [INS_WIDTH-1:0]       ins_rd_data,
  output logic [DATA_ADDR_WIDTH-1:0] dat_rd_addr,
  input  logic [DATA_WIDTH-1:0]      dat_rd_data,
  output logic                       res_wr_en,
  output logic [DATA_ADDR_WIDTH-1:0] res_wr_addr,
  output logic [DATA_WIDTH-1:0]      res_wr_data,
  output logic                       txByteStart,
  output logic [UART_WIDTH-1:0]      byteForTx,
  input  logic                       tx_ready,
  input  logic                       rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0]      byteFromRx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH, UART_WIDTH);
  localparam int unsigned ACC_WIDTH      = BYTES_PER_WORD * UART_WIDTH;
  localparam int unsigned BCNT_WIDTH     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCNT_WIDTH-1:0]     LAST_BYTE = BCNT_WIDTH'(BYTES_PER_WORD - 1);
  localparam logic [INS_ADDR_WIDTH-1:0] INS_LAST  = '1;

  link_state_t                state;
  logic                       load;
  logic                       word_sent;
  logic [DATA_ADDR_WIDTH-1:0] data_last_q;
  logic [DATA_ADDR_WIDTH-1:0] res_start_q;
  logic [DATA_ADDR_WIDTH-1:0] res_end_q;
  logic [DATA_ADDR_WIDTH-1:0] res_addr;
  logic [ACC_WIDTH-1:0]       acc;
  logic [BCNT_WIDTH-1:0]      rx_idx;

  logic [DATA_WIDTH-1:0]      tx_word;
  logic [BCNT_WIDTH-1:0]      tx_last;
  logic [ACC_WIDTH-1:0]       acc_next;

  // Serializer source select and receive byte-lane merge.
  always_comb begin
    tx_word  = dat_rd_data;
    tx_last  = LAST_BYTE;
    if (state == SEND_INS) begin
      tx_word = DATA_WIDTH'(ins_rd_data);
      tx_last = '0;
    end
    acc_next = acc | (ACC_WIDTH'(byteFromRx) << (32'(rx_idx) * UART_WIDTH));
  end

  word_byte_serializer #(
    .WORD_WIDTH (DATA_WIDTH),
    .UART_WIDTH (UART_WIDTH)
  ) u_ser (
    .clk         (clk),
    .rstN        (rstN),
    .load        (load),
    .word        (tx_word),
    .last_byte   (tx_last),
    .tx_ready    (tx_ready),
    .txByteStart (txByteStart),
    .byteForTx   (byteForTx),
    .word_sent   (word_sent)
  );

  // Session sequencing: instruction stream, data stream, result capture.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state       <= IDLE;
      load        <= 1'b0;
      data_last_q <= '0;
      res_start_q <= '0;
      res_end_q   <= '0;
      res_addr    <= '0;
      acc         <= '0;
      rx_idx      <= '0;
      ins_rd_addr <= '0;
      dat_rd_addr <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      load      <= 1'b0;
      res_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            data_last_q <= data_last_addr;
            res_start_q <= res_start_addr;
            res_end_q   <= res_end_addr;
            ins_rd_addr <= '0;
            dat_rd_addr <= '0;
            acc         <= '0;
            rx_idx      <= '0;
            load        <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            state       <= SEND_INS;
          end
        end
        SEND_INS: begin
          if (word_sent) begin
            load <= 1'b1;
            if (ins_rd_addr == INS_LAST) state <= SEND_DATA;
            else ins_rd_addr <= ins_rd_addr + INS_ADDR_WIDTH'(1);
          end
        end
        SEND_DATA: begin
          if (word_sent) begin
            if (dat_rd_addr == data_last_q) begin
              if (res_start_q > res_end_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                err   <= 1'b1;
                state <= DONE;
              end else begin
                res_addr <= res_start_q;
                state    <= RECV_RES;
              end
            end else begin
              dat_rd_addr <= dat_rd_addr + DATA_ADDR_WIDTH'(1);
              load        <= 1'b1;
            end
          end
        end
        RECV_RES: begin
          if (rx_new_byte_indicate) begin
            if (rx_idx == LAST_BYTE) begin
              res_wr_en   <= 1'b1;
              res_wr_addr <= res_addr;
              res_wr_data <= DATA_WIDTH'(acc_next);
              acc         <= '0;
              rx_idx      <= '0;
              if (res_addr == res_end_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                res_addr <= res_addr + DATA_ADDR_WIDTH'(1);
              end
            end else begin
              acc    <= acc_next;
              rx_idx <= rx_idx + BCNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_link.sv
// Bench for uart_host_link: plays the UART and the memories, predicts the byte
// stream and result writes from the image contents and address ranges.
module tb_uart_host_link;

  localparam int unsigned N_INS = 256;
  localparam int unsigned BPW   = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [11:0] data_last_addr, res_start_addr, res_end_addr;
  logic [7:0]  ins_rd_addr;
  logic [7:0]  ins_rd_data;
  logic [11:0] dat_rd_addr;
  logic [59:0] dat_rd_data;
  logic        res_wr_en;
  logic [11:0] res_wr_addr;
  logic [59:0] res_wr_data;
  logic        txByteStart;
  logic [7:0]  byteForTx;
  logic        tx_ready;
  logic        rx_new_byte_indicate;
  logic [7:0]  byteFromRx;
  logic        busy, done, err;

  uart_host_link dut (
    .clk                  (clk),
    .rstN                 (rstN),
    .start                (start),
    .data_last_addr       (data_last_addr),
    .res_start_addr       (res_start_addr),
    .res_end_addr         (res_end_addr),
    .ins_rd_addr          (ins_rd_addr),
    .ins_rd_data          (ins_rd_data),
    .dat_rd_addr          (dat_rd_addr),
    .dat_rd_data          (dat_rd_data),
    .res_wr_en            (res_wr_en),
    .res_wr_addr          (res_wr_addr),
    .res_wr_data          (res_wr_data),
    .txByteStart          (txByteStart),
    .byteForTx            (byteForTx),
    .tx_ready             (tx_ready),
    .rx_new_byte_indicate (rx_new_byte_indicate),
    .byteFromRx           (byteFromRx),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  always #5 clk = ~clk;

  logic [7:0]  ins_mem [N_INS];
  logic [59:0] dat_mem [4096];

  // Synchronous-read image memories.
  always @(posedge clk) begin
    ins_rd_data <= ins_mem[ins_rd_addr];
    dat_rd_data <= dat_mem[dat_rd_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int lo_min = 1;
  int lo_max = 3;
  int rst_epoch = 0;

  logic [7:0]  tx_obs[$];
  logic [7:0]  exp_tx[$];
  logic [11:0] wr_addr_obs[$];
  logic [59:0] wr_data_obs[$];
  logic [11:0] exp_wr_addr[$];
  logic [59:0] exp_wr_data[$];
  logic [63:0] rx_words[$];
  logic [7:0]  lit [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter stand-in: takes each pulse, holds tx_ready low a while.
  initial begin
    logic [7:0] b;
    int         lo;
    int         ep;
    bit         ok;
    forever begin
      @(negedge clk);
      if (txByteStart) begin
        b  = byteForTx;
        ep = rst_epoch;
        tx_obs.push_back(b);
        tx_ready = 1'b0;
        ok = 1'b1;
        lo = $urandom_range(lo_max, lo_min);
        repeat (lo) begin
          @(negedge clk);
          if (txByteStart || byteForTx != b) ok = 1'b0;
        end
        tx_ready = 1'b1;
        if (ep == rst_epoch) chk("tx_hold", 64'(ok), 64'd1);
      end
    end
  end

  // Result RAM write capture.
  initial begin
    forever begin
      @(negedge clk);
      if (res_wr_en) begin
        wr_addr_obs.push_back(res_wr_addr);
        wr_data_obs.push_back(res_wr_data);
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input int gap);
    rx_new_byte_indicate = 1'b1;
    byteFromRx = b;
    @(negedge clk);
    rx_new_byte_indicate = 1'b0;
    byteFromRx = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Expected byte stream and writes straight from images and ranges.
  task automatic build_model(input int last, input int rs, input int re);
    logic [63:0] w;
    exp_tx.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    for (int a = 0; a < N_INS; a++) exp_tx.push_back(ins_mem[a]);
    for (int d = 0; d <= last; d++) begin
      w = {4'h0, dat_mem[d]};
      for (int k = 0; k < BPW; k++) exp_tx.push_back(8'(w >> (8 * k)));
    end
    if (rs <= re)
      for (int r = rs; r <= re; r++) begin
        exp_wr_addr.push_back(12'(r));
        exp_wr_data.push_back(rx_words[r - rs][59:0]);
      end
  endtask

  task automatic pulse_start(input int last, input int rs, input int re);
    @(negedge clk);
    data_last_addr = 12'(last);
    res_start_addr = 12'(rs);
    res_end_addr   = 12'(re);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_last_addr = 12'($urandom);
    res_start_addr = 12'($urandom);
    res_end_addr   = 12'($urandom);
    chk("busy_at_start", 64'(busy), 64'd1);
    chk("done_cleared", 64'(done), 64'd0);
  endtask

  task automatic run_session(input int last, input int rs, input int re, input bit stray);
    int budget;
    bit stray_sent;
    build_model(last, rs, re);
    tx_obs.delete();
    wr_addr_obs.delete();
    wr_data_obs.delete();
    pulse_start(last, rs, re);
    budget = 60000;
    stray_sent = 1'b0;
    while (tx_obs.size() < exp_tx.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      if (stray && !stray_sent && tx_obs.size() >= N_INS + 2) begin
        stray_sent = 1'b1;
        send_rx(8'h5A, 0);
      end
    end
    chk("tx_phase_timeout", 64'(budget > 0), 64'd1);
    budget = 1000;
    while (!tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    if (rs <= re)
      foreach (rx_words[w])
        for (int k = 0; k < BPW; k++) send_rx(8'(rx_words[w] >> (8 * k)), $urandom_range(2, 0));
    budget = 1000;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_timeout", 64'(budget > 0), 64'd1);
    repeat (5) @(negedge clk);
    chk("done_level", 64'(done), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("err_flag", 64'(err), 64'(rs > re));
    chk("tx_count", 64'(tx_obs.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_obs.size(); i++)
      chk("tx_byte", 64'(tx_obs[i]), 64'(exp_tx[i]));
    chk("wr_count", 64'(wr_addr_obs.size()), 64'(exp_wr_addr.size()));
    for (int i = 0; i < exp_wr_addr.size() && i < wr_addr_obs.size(); i++) begin
      chk("wr_addr", 64'(wr_addr_obs[i]), 64'(exp_wr_addr[i]));
      chk("wr_data", 64'(wr_data_obs[i]), 64'(exp_wr_data[i]));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_txstart"}, 64'(txByteStart), 64'd0);
    chk({tag, "_txbyte"}, 64'(byteForTx), 64'd0);
    chk({tag, "_wren"}, 64'(res_wr_en), 64'd0);
    chk({tag, "_wraddr"}, 64'(res_wr_addr), 64'd0);
    chk({tag, "_wrdata"}, 64'(res_wr_data), 64'd0);
    chk({tag, "_insaddr"}, 64'(ins_rd_addr), 64'd0);
    chk({tag, "_dataddr"}, 64'(dat_rd_addr), 64'd0);
  endtask

  task automatic randomize_images();
    for (int a = 0; a < N_INS; a++) ins_mem[a] = 8'($urandom);
    for (int d = 0; d < 16; d++) dat_mem[d] = {28'($urandom), 32'($urandom)};
  endtask

  task automatic random_rx_words(input int n);
    rx_words.delete();
    for (int i = 0; i < n; i++) rx_words.push_back({32'($urandom), 32'($urandom)});
  endtask

  initial begin
    watchdog();
  end

  task automatic watchdog();
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    int rs, re, last, sz, budget;
    rstN = 1'b0;
    start = 1'b0;
    tx_ready = 1'b1;
    rx_new_byte_indicate = 1'b0;
    byteFromRx = 8'h00;
    data_last_addr = '0;
    res_start_addr = '0;
    res_end_addr = '0;
    for (int d = 0; d < 4096; d++) dat_mem[d] = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rstN = 1'b1;

    // Directed: address-valued ins image, one data word, two result words.
    for (int a = 0; a < N_INS; a++) ins_mem[a] = 8'(a);
    dat_mem[0] = 60'h0123456789ABCDE;
    rx_words.delete();
    rx_words.push_back(64'h0FEDCBA987654321);
    rx_words.push_back(64'h0000000000000001);
    run_session(0, 9, 10, 1'b0);
    lit = '{8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    for (int k = 0; k < BPW; k++)
      if (tx_obs.size() > N_INS + k) chk("frame_literal", 64'(tx_obs[N_INS + k]), 64'(lit[k]));

    // Slow transmitter: tx_ready low 100 cycles after each pulse.
    randomize_images();
    lo_min = 100;
    lo_max = 100;
    last = $urandom_range(3, 1);
    rs = $urandom_range(4000, 0);
    re = rs + $urandom_range(3, 0);
    random_rx_words(re - rs + 1);
    run_session(last, rs, re, 1'b0);
    lo_min = 1;
    lo_max = 3;

    // Inverted result range: error, no writes.
    randomize_images();
    random_rx_words(0);
    run_session($urandom_range(3, 0), 8, 5, 1'b0);

    // Stray rx byte during the data phase.
    randomize_images();
    random_rx_words(3);
    run_session(2, 20, 22, 1'b1);

    // Reset in the middle of the data phase, then a full replay.
    randomize_images();
    last = 4;
    rs = $urandom_range(100, 0);
    re = rs + 1;
    tx_obs.delete();
    pulse_start(last, rs, re);
    budget = 20000;
    while (tx_obs.size() < N_INS + 4 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reset_reach_timeout", 64'(budget > 0), 64'd1);
    rst_epoch++;
    rstN = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    rstN = 1'b1;
    sz = tx_obs.size();
    repeat (10) @(negedge clk);
    chk("no_tx_after_reset", 64'(tx_obs.size()), 64'(sz));
    chk("idle_after_reset", 64'(busy), 64'd0);
    budget = 1000;
    while (!tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    random_rx_words(re - rs + 1);
    run_session(last, rs, re, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
